// File: rtl/gbc_mbc_pkg.sv
// rtl/gbc_mbc_pkg.sv - shared MBC constants, FSM state and banking-mode types
package gbc_mbc_pkg;

  localparam logic [15:0] MBC_RAMEN_BASE = 16'h0000;
  localparam logic [15:0] MBC_ROMLO_BASE = 16'h2000;
  localparam logic [15:0] MBC_HI_BASE    = 16'h4000;
  localparam logic [15:0] MBC_MODE_BASE  = 16'h6000;
  localparam logic [15:0] EXTRAM_BASE    = 16'hA000;

  localparam logic [3:0] RAM_ENABLE_KEY = 4'hA;

  typedef enum logic {
    WD_IDLE = 1'b0,
    WD_HELD = 1'b1
  } wd_state_e;

  typedef enum logic {
    MODE_ROM = 1'b0,
    MODE_RAM = 1'b1
  } mbc_mode_e;

endpackage

// File: rtl/mbc_write_detect.sv
// rtl/mbc_write_detect.sv - turns a possibly long active-low write strobe into one commit pulse
module mbc_write_detect
  import gbc_mbc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic we_l,
  output logic commit
);

  wd_state_e state;
  wd_state_e state_next;

  // Reset lands in HELD so a strobe already low when reset releases is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WD_HELD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    case (state)
      WD_IDLE: begin
        if (!we_l) begin
          state_next = WD_HELD;
          commit     = 1'b1;
        end
      end
      WD_HELD: begin
        if (we_l) begin
          state_next = WD_IDLE;
        end
      end
    endcase
  end

endmodule

// File: rtl/mbc1_controller.sv
// rtl/mbc1_controller.sv - MBC1 bank registers and CPU-to-ROM/RAM address translation
module mbc1_controller
  import gbc_mbc_pkg::*;
#(
  parameter int ROM_BANKS_LOG2 = 7,
  parameter int RAM_BANKS_LOG2 = 2
) (
  input  logic                         I_CLK,
  input  logic                         I_RESET,
  input  logic [15:0]                  I_CARTRIDGE_ADDR,
  input  logic [7:0]                   I_CARTRIDGE_DATA,
  input  logic                         I_CARTRIDGE_WE_L,
  input  logic                         I_CARTRIDGE_RE_L,
  output logic                         O_ROM_CS,
  output logic [14+ROM_BANKS_LOG2-1:0] O_ROM_ADDR,
  output logic                         O_RAM_CS,
  output logic [13+RAM_BANKS_LOG2-1:0] O_RAM_ADDR,
  output logic                         O_RAM_WE,
  output logic                         O_RAM_EN
);

  localparam int ROM_AW = 14 + ROM_BANKS_LOG2;
  localparam int RAM_AW = 13 + RAM_BANKS_LOG2;

  logic      ram_en;
  logic [4:0] rom_lo;
  logic [1:0] bank_hi;
  mbc_mode_e mode;
  logic      ram_we;
  logic      commit;

  logic       hit_ramen;
  logic       hit_romlo;
  logic       hit_hi;
  logic       hit_mode;
  logic       hit_extram;
  logic [6:0] rom_bank;
  logic [1:0] ram_bank;

  logic unused_data;
  assign unused_data = ^I_CARTRIDGE_DATA[7:5];

  mbc_write_detect u_write_detect (
    .clk    (I_CLK),
    .rst    (I_RESET),
    .we_l   (I_CARTRIDGE_WE_L),
    .commit (commit)
  );

  assign hit_ramen  = (I_CARTRIDGE_ADDR[15:13] == MBC_RAMEN_BASE[15:13]);
  assign hit_romlo  = (I_CARTRIDGE_ADDR[15:13] == MBC_ROMLO_BASE[15:13]);
  assign hit_hi     = (I_CARTRIDGE_ADDR[15:13] == MBC_HI_BASE[15:13]);
  assign hit_mode   = (I_CARTRIDGE_ADDR[15:13] == MBC_MODE_BASE[15:13]);
  assign hit_extram = (I_CARTRIDGE_ADDR[15:13] == EXTRAM_BASE[15:13]);

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      ram_en  <= 1'b0;
      rom_lo  <= 5'd1;
      bank_hi <= 2'd0;
      mode    <= MODE_ROM;
      ram_we  <= 1'b0;
    end else begin
      ram_we <= commit && hit_extram && ram_en;
      if (commit) begin
        if (hit_ramen) begin
          ram_en <= (I_CARTRIDGE_DATA[3:0] == RAM_ENABLE_KEY);
        end
        // Bank 0 cannot be mapped into the switchable window; it aliases to 1.
        if (hit_romlo) begin
          rom_lo <= (I_CARTRIDGE_DATA[4:0] == 5'd0) ? 5'd1 : I_CARTRIDGE_DATA[4:0];
        end
        if (hit_hi) begin
          bank_hi <= I_CARTRIDGE_DATA[1:0];
        end
        if (hit_mode) begin
          mode <= mbc_mode_e'(I_CARTRIDGE_DATA[0]);
        end
      end
    end
  end

  always_comb begin
    rom_bank = {bank_hi, rom_lo};
    if (!I_CARTRIDGE_ADDR[14]) begin
      rom_bank = (mode == MODE_RAM) ? {bank_hi, 5'b0} : 7'd0;
    end
  end

  assign ram_bank = (mode == MODE_RAM) ? bank_hi : 2'd0;

  // Casting to the port width drops bank bits the memories do not have.
  assign O_ROM_ADDR = ROM_AW'({rom_bank, I_CARTRIDGE_ADDR[13:0]});
  assign O_RAM_ADDR = RAM_AW'({ram_bank, I_CARTRIDGE_ADDR[12:0]});

  assign O_ROM_CS = !I_CARTRIDGE_ADDR[15] && !I_CARTRIDGE_RE_L && I_CARTRIDGE_WE_L;
  assign O_RAM_CS = hit_extram && ram_en && (!I_CARTRIDGE_RE_L || !I_CARTRIDGE_WE_L);
  assign O_RAM_WE = ram_we;
  assign O_RAM_EN = ram_en;

endmodule

// File: tb/tb_mbc1_controller.sv
// tb/tb_mbc1_controller.sv - randomized bench for mbc1_controller against a behavioural model
module tb_mbc1_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        we_l;
  logic        re_l;

  logic        rom_cs, ram_cs, ram_we, ram_en;
  logic [20:0] rom_addr;
  logic [14:0] ram_addr;
  logic        rom_cs5, ram_cs5, ram_we5, ram_en5;
  logic [18:0] rom_addr5;
  logic [14:0] ram_addr5;

  int n_checks;
  int n_fail;

  int m_ram_en, m_rom_lo, m_bank_hi, m_mode, m_armed, m_we;

  always #5 clk = ~clk;

  mbc1_controller dut (
    .I_CLK            (clk),
    .I_RESET          (rst),
    .I_CARTRIDGE_ADDR (addr),
    .I_CARTRIDGE_DATA (data),
    .I_CARTRIDGE_WE_L (we_l),
    .I_CARTRIDGE_RE_L (re_l),
    .O_ROM_CS         (rom_cs),
    .O_ROM_ADDR       (rom_addr),
    .O_RAM_CS         (ram_cs),
    .O_RAM_ADDR       (ram_addr),
    .O_RAM_WE         (ram_we),
    .O_RAM_EN         (ram_en)
  );

  mbc1_controller #(.ROM_BANKS_LOG2(5), .RAM_BANKS_LOG2(2)) dut5 (
    .I_CLK            (clk),
    .I_RESET          (rst),
    .I_CARTRIDGE_ADDR (addr),
    .I_CARTRIDGE_DATA (data),
    .I_CARTRIDGE_WE_L (we_l),
    .I_CARTRIDGE_RE_L (re_l),
    .O_ROM_CS         (rom_cs5),
    .O_ROM_ADDR       (rom_addr5),
    .O_RAM_CS         (ram_cs5),
    .O_RAM_ADDR       (ram_addr5),
    .O_RAM_WE         (ram_we5),
    .O_RAM_EN         (ram_en5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ram_en  = 0;
    m_rom_lo  = 1;
    m_bank_hi = 0;
    m_mode    = 0;
    m_armed   = 0;
    m_we      = 0;
  endtask

  function automatic int exp_rom_addr(input int log2, input int a);
    int bank;
    if (a < 16384) bank = (m_mode != 0) ? m_bank_hi * 32 : 0;
    else           bank = m_bank_hi * 32 + m_rom_lo;
    return (bank % (1 << log2)) * 16384 + (a % 16384);
  endfunction

  function automatic int exp_ram_addr(input int a);
    int rbank;
    rbank = (m_mode != 0) ? m_bank_hi : 0;
    return (rbank % 4) * 8192 + (a % 8192);
  endfunction

  task automatic check_outputs();
    int  a;
    bit  ext;
    a   = int'(addr);
    ext = (a >= 40960) && (a < 49152);
    check("rom_cs",  32'(rom_cs),  32'((a < 32768) && !re_l && we_l));
    check("rom_cs5", 32'(rom_cs5), 32'((a < 32768) && !re_l && we_l));
    if (a < 32768) begin
      check("rom_addr",  32'(rom_addr),  32'(exp_rom_addr(7, a)));
      check("rom_addr5", 32'(rom_addr5), 32'(exp_rom_addr(5, a)));
    end
    check("ram_cs", 32'(ram_cs), 32'(ext && (m_ram_en != 0) && (!re_l || !we_l)));
    if (ext) check("ram_addr", 32'(ram_addr), 32'(exp_ram_addr(a)));
    check("ram_we",  32'(ram_we),  32'(m_we));
    check("ram_we5", 32'(ram_we5), 32'(m_we));
    check("ram_en",  32'(ram_en),  32'(m_ram_en));
  endtask

  // A write counts once per low period, and only if the strobe was seen high first.
  task automatic model_edge();
    int a, d, nxt_we;
    if (rst) return;
    a = int'(addr);
    d = int'(data);
    nxt_we = 0;
    if (!we_l && m_armed != 0) begin
      if (a < 8192)                    m_ram_en  = ((d % 16) == 10) ? 1 : 0;
      else if (a < 16384)              m_rom_lo  = ((d % 32) == 0) ? 1 : (d % 32);
      else if (a < 24576)              m_bank_hi = d % 4;
      else if (a < 32768)              m_mode    = d % 2;
      else if (a >= 40960 && a < 49152 && m_ram_en != 0) nxt_we = 1;
    end
    m_armed = we_l ? 1 : 0;
    m_we    = nxt_we;
  endtask

  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic write_bus(input logic [15:0] a, input logic [7:0] d);
    addr = a; data = d; re_l = 1'b1; we_l = 1'b0;
    step();
    step();
    we_l = 1'b1;
    step();
  endtask

  task automatic probe(input logic [15:0] a);
    addr = a; re_l = 1'b0; we_l = 1'b1;
    #1;
  endtask

  task automatic held_write(input logic [15:0] a, input logic [7:0] d, input int n, output int pulses);
    addr = a; data = d; re_l = 1'b1; we_l = 1'b0;
    pulses = 0;
    repeat (n) begin
      step();
      pulses += int'(ram_we);
    end
    we_l = 1'b1;
    step();
  endtask

  initial begin
    int p;
    int r;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; addr = '0; data = '0; we_l = 1'b1; re_l = 1'b1;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();

    probe(16'h4000);
    check("tp_reset_rom_addr", 32'(rom_addr), 32'h04000);
    check("tp_reset_rom_cs",   32'(rom_cs),   32'd1);
    check("tp_reset_ram_en",   32'(ram_en),   32'd0);
    step();

    write_bus(16'h2100, 8'h00);
    probe(16'h7FFF);
    check("tp_bank0_is_1", 32'(rom_addr), 32'h07FFF);
    step();
    write_bus(16'h2100, 8'h1F);
    probe(16'h4000);
    check("tp_bank1f", 32'(rom_addr), 32'h7C000);
    step();

    write_bus(16'h4000, 8'h02);
    write_bus(16'h2000, 8'h05);
    write_bus(16'h6000, 8'h01);
    probe(16'h0000);
    check("tp_mode1_low", 32'(rom_addr), 32'h100000);
    step();
    probe(16'h4000);
    check("tp_mode1_high", 32'(rom_addr), 32'h114000);
    step();
    probe(16'hA010);
    check("tp_mode1_ram_addr", 32'(ram_addr), 32'h4010);
    step();

    held_write(16'hA000, 8'h3A, 5, p);
    check("tp_ram_we_disabled", 32'(p), 32'd0);
    write_bus(16'h0000, 8'h0A);
    check("tp_ram_en_set", 32'(ram_en), 32'd1);
    held_write(16'hA000, 8'h3A, 5, p);
    check("tp_ram_we_single", 32'(p), 32'd1);

    addr = 16'hA000; data = 8'h55; re_l = 1'b1; we_l = 1'b0;
    step();
    check("tp_ram_we_before_rst", 32'(ram_we), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    check("tp_ram_we_async_clr", 32'(ram_we), 32'd0);

    addr = 16'h2000; data = 8'h07;
    step();
    rst = 1'b0;
    step();
    step();
    addr = 16'h4000;
    #1;
    check("tp_rst_write_dropped", 32'(rom_addr), 32'h04000);
    step();
    addr = 16'h2000; we_l = 1'b1;
    step();
    we_l = 1'b0;
    step();
    step();
    probe(16'h4000);
    check("tp_rom_lo_7", 32'(rom_addr), 32'h1C000);
    step();

    write_bus(16'h4000, 8'h03);
    write_bus(16'h2000, 8'h02);
    probe(16'h4000);
    check("tp_wrap_5bit", 32'(rom_addr5), 32'h08000);
    check("tp_nowrap_7bit", 32'(rom_addr), 32'h188000);
    step();

    for (int i = 0; i < 1500; i++) begin
      if (i == 0 || $urandom_range(0, 2) != 0) begin
        r = $urandom_range(0, 9);
        if (r < 4)      addr = 16'(r * 8192 + $urandom_range(0, 8191));
        else if (r < 7) addr = 16'(40960 + $urandom_range(0, 8191));
        else            addr = 16'($urandom);
        data = 8'($urandom);
        if (r == 0 && $urandom_range(0, 1) == 1) data[3:0] = 4'hA;
        we_l = ($urandom_range(0, 2) != 0);
        re_l = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbc1_controller.md
# mbc1_controller

MBC1-style memory bank controller for the simulated Game Boy cartridge. Sits between the CPU-side cartridge bus and the cartridge ROM/RAM block memories. Captures bank-select writes to the ROM address space, translates 16-bit CPU addresses into banked ROM and external-RAM addresses, and issues single-cycle RAM write strobes. One controller instance per cartridge; the downstream memories are plain synchronous BRAMs.

## Interface

Parameters:
- ROM_BANKS_LOG2, default 7 — log2 of the number of 16 KB ROM banks (7 = 2 MB).
- RAM_BANKS_LOG2, default 2 — log2 of the number of 8 KB external-RAM banks (2 = 32 KB).

Ports:
- I_CLK  in  1  system clock; all state on rising edge.
- I_RESET  in  1  asynchronous, active-high reset.
- I_CARTRIDGE_ADDR  in  16  CPU cartridge address.
- I_CARTRIDGE_DATA  in  8  CPU write data.
- I_CARTRIDGE_WE_L  in  1  write strobe, active low; may be held low for several cycles.
- I_CARTRIDGE_RE_L  in  1  read strobe, active low.
- O_ROM_CS  out  1  ROM access, address in 0x0000–0x7FFF and RE_L low.
- O_ROM_ADDR  out  14+ROM_BANKS_LOG2  banked ROM byte address.
- O_RAM_CS  out  1  external-RAM access, 0xA000–0xBFFF, RAM enabled, RE_L or WE_L low.
- O_RAM_ADDR  out  13+RAM_BANKS_LOG2  banked RAM byte address.
- O_RAM_WE  out  1  one-cycle RAM write strobe.
- O_RAM_EN  out  1  current RAM-enable register value (status).

## Operation

- Registers: ram_en (1b), rom_lo (5b), bank_hi (2b), mode (1b).
- Write decode on commit (see FSM):
  - 0x0000–0x1FFF: ram_en = (data[3:0] == 4'hA).
  - 0x2000–0x3FFF: rom_lo = data[4:0]; a value of 0 is stored as 1.
  - 0x4000–0x5FFF: bank_hi = data[1:0].
  - 0x6000–0x7FFF: mode = data[0].
  - 0xA000–0xBFFF with ram_en = 1: O_RAM_WE pulses. With ram_en = 0, the write is dropped.
  - All other addresses: ignored.
- ROM translation:
  - 0x0000–0x3FFF: bank = mode ? {bank_hi,5'b0} : 0.
  - 0x4000–0x7FFF: bank = {bank_hi,rom_lo}.
  - O_ROM_ADDR = {bank masked to ROM_BANKS_LOG2 bits, addr[13:0]}. Upper bits are truncated, so banks beyond the ROM size wrap.
- RAM translation:
  - rbank = mode ? bank_hi : 0, masked to RAM_BANKS_LOG2 bits.
  - O_RAM_ADDR = {rbank, addr[12:0]}. When RAM_BANKS_LOG2 = 0, the bank is ignored.
- Write-detect FSM, states IDLE and HELD:
  - IDLE → HELD when WE_L = 0. The write is committed on that same clock edge.
  - HELD → IDLE when WE_L = 1. No further commit occurs while in HELD.
- Simultaneous WE_L and RE_L low: the write is processed and ROM reads are suppressed (O_ROM_CS = 0).

## Timing

- Reset state:
  - ram_en = 0, rom_lo = 1, bank_hi = 0, mode = 0.
  - FSM = HELD, so a write held low through reset is never committed.
  - O_RAM_WE = 0.
  - Other outputs follow the combinational rules below using these reset register values.
- O_ROM_ADDR, O_RAM_ADDR, O_ROM_CS and O_RAM_CS are combinational from the inputs and the registered state: zero-cycle latency.
- A bank-register write committed at edge N affects the translated addresses from edge N onward, i.e. in cycle N+1.
- O_RAM_WE is registered:
  - Asserted for exactly the one cycle following the commit edge.
  - O_RAM_ADDR at that time reflects the still-present address. The bus must hold address and data for at least 2 cycles with WE_L low.
- Back-to-back writes require WE_L high for at least one sampled edge between them. Otherwise the second write is lost.
- Asynchronous reset mid-write clears O_RAM_WE immediately.

## Structure

- Shared package gbc_mbc_pkg holds:
  - region base constants (MBC_RAMEN_BASE, MBC_ROMLO_BASE, MBC_HI_BASE, MBC_MODE_BASE, EXTRAM_BASE);
  - RAM enable key 4'hA;
  - FSM state typedef;
  - mode enum (MODE_ROM, MODE_RAM).
- Sub-module mbc_write_detect contains the IDLE/HELD FSM and emits a one-cycle commit pulse. It is reused by future MBC3/MBC5 controllers.
- Address translation and bank registers stay in mbc1_controller.

## Test plan

- Reset, then read 0x4000 → O_ROM_ADDR = 0x04000 (bank 1), O_ROM_CS = 1, O_RAM_EN = 0.
- Write 0x00 to 0x2100, then read 0x7FFF → bank stays 1, O_ROM_ADDR = 0x07FFF. Write 0x1F then read 0x4000 → O_ROM_ADDR = 0x7C000.
- Write bank_hi = 2, rom_lo = 5, mode 1, then read 0x0000 → O_ROM_ADDR = 0x100000; read 0x4000 → 0x114000. Under mode 1, a RAM access at 0xA010 gives O_RAM_ADDR = 0x4010.
- Write 0x3A to 0xA000 while disabled → no O_RAM_WE. Write 0x0A to 0x0000, then 0x3A to 0xA000 → single O_RAM_WE pulse even with WE_L held low for 5 cycles.
- Hold WE_L low across assert/deassert of I_RESET with address 0x2000 and data 0x07 → rom_lo remains 1 after reset. Then toggle WE_L high→low → rom_lo = 7.
- Set ROM_BANKS_LOG2 = 5, write bank_hi = 3, rom_lo = 2, then read 0x4000 → bank wraps to 2, O_ROM_ADDR = 0x08000.
